debounce_sync: RTL and testbench
================================

# debounce_sync

Input-conditioning stage that sits directly upstream of the lab's D flip-flop storage stages and drives their `D` input. It takes a raw, asynchronous, bouncing one-bit signal (push-button or switch), synchronises it into the `clk` domain with a two-stage synchroniser, and qualifies every level change with a stability counter. It outputs a clean registered level plus a one-cycle rising-edge pulse, so downstream flip-flops and counters see exactly one transition per physical press.

## Interface
- `STABLE_CYCLES`, 4: consecutive synchronised samples that must differ from `dout` before `dout` changes; legal range 2..2^CNT_W.
- `CNT_W`, 3: stability counter width; must satisfy 2^CNT_W >= STABLE_CYCLES.

- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low (0 = reset); asserts immediately, released synchronously by the system.
- `din`  input  1  raw asynchronous input, may bounce.
- `dout`  output  1  debounced, registered level.
- `rise_pulse`  output  1  registered, high for exactly one cycle when `dout` goes 0->1.
- `busy`  output  1  high while a candidate change is being qualified (state COUNT).
- `fall_pulse`  output  1  present only with `DEBOUNCE_FALL_PULSE_EN`; one-cycle pulse when `dout` goes 1->0.

## Operation
- Synchroniser: `s1 <= din`, `s2 <= s1` every edge; only `s2` is used by the FSM.
- Reset (`reset`=0): `s1`, `s2`, `dout`, `rise_pulse`, `fall_pulse`, `cnt` = 0; state = IDLE; `busy` = 0.
- FSM states: IDLE, COUNT.
- IDLE: if `s2 != dout` -> COUNT, `cnt <= 1`; else stay, `cnt <= 0`.
- COUNT:
  - `s2 == dout` (bounce back) -> IDLE, `cnt <= 0`, `dout` unchanged, no pulse.
  - `s2 != dout` and `cnt == STABLE_CYCLES-1` -> commit: `dout <= s2`, IDLE, `cnt <= 0`, `rise_pulse <= s2` (`fall_pulse <= ~s2` if enabled).
  - else `cnt <= cnt + 1`.
- Pulses default to 0 on every edge not performing a commit, so they never last longer than one cycle.
- `busy` = (state == COUNT), decoded from the state register.
- Counter never wraps: it is cleared at or before reaching STABLE_CYCLES-1.

## Timing
- `din` settles before edge k: `s1` updates at k, `s2` at k+1, FSM first sees the new value at edge k+2 (enters COUNT, `busy`=1).
- Commit edge is k+STABLE_CYCLES+1: `dout` and the pulse update there. With STABLE_CYCLES=4, that is edge k+5.
- `rise_pulse` is high only in the cycle after the commit edge. `busy` falls at the commit edge.
- A `s2` excursion shorter than STABLE_CYCLES samples produces no `dout` change and no pulse.
- Bounce during COUNT restarts qualification from IDLE. The next differing sample re-enters COUNT with `cnt=1`; there is no carry-over.
- Reset mid-COUNT aborts immediately: `dout` = 0, pulses = 0, `busy` = 0; there is no pulse on release.
- After reset release with `din`=1 held, a rise is committed at the normal latency (first `s2`=1 sample + STABLE_CYCLES-1 edges).

## Configuration
- `DEBOUNCE_FALL_PULSE_EN` defined: `fall_pulse` port and register exist; it pulses one cycle on every committed 1->0 change and resets to 0.
- Not defined: the port and register are absent, and the falling commit updates only `dout`. All other behaviour is identical.

## Test plan
- Reset: hold `reset`=0 with `din` toggling -> `dout`=0, `rise_pulse`=0, `busy`=0 throughout; `fall_pulse`=0 if enabled.
- Clean press (STABLE_CYCLES=4): `din` 0->1 before edge k, held -> `busy`=1 from edge k+2, `dout`=1 at edge k+5, `rise_pulse`=1 for exactly one cycle, `busy`=0 at edge k+5.
- Glitch: `din`=1 for 3 cycles then 0 -> `dout` stays 0, `rise_pulse` never asserts, `busy` returns to 0.
- Bounce: `din` pattern 1,0,1,1,0,1 then steady 1 -> exactly one `rise_pulse`, committed 4 `s2` samples after the last 0->1 seen by `s2`.
- Release with macro on: `dout`=1, `din`->0 held -> `dout`=0 at k+5, `fall_pulse` one cycle, `rise_pulse` stays 0. With macro off, `dout`=0 at k+5 only.
- Reset mid-count: assert `reset`=0 while `busy`=1 with `cnt`=2 -> outputs 0 immediately; release with `din`=1 -> full STABLE_CYCLES qualification repeated before `dout`=1.

Source files
------------

// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus stability-qualified debouncer with registered edge pulses.
// Optional fall_pulse output is enabled by defining DEBOUNCE_FALL_PULSE_EN.
module debounce_sync #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise_pulse,
  output logic busy
`ifdef DEBOUNCE_FALL_PULSE_EN
  ,
  output logic fall_pulse
`endif
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1, r_s2;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout, r_rise;
  logic             w_diff, w_last;

  assign w_diff = (r_s2 != r_dout);
  assign w_last = (r_cnt == CNT_LAST);

`ifdef DEBOUNCE_FALL_PULSE_EN
  logic r_fall;
  assign fall_pulse = r_fall;
`endif

  // Pulses default low every edge; only the commit branch raises one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
      r_fall  <= 1'b0;
`endif
    end else begin
      r_s1   <= din;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
      r_fall <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_diff) begin
            r_state <= S_COUNT;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        default: begin
          if (!w_diff) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_last) begin
            r_dout  <= r_s2;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rise  <= r_s2;
`ifdef DEBOUNCE_FALL_PULSE_EN
            r_fall  <= ~r_s2;
`endif
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign rise_pulse = r_rise;
  assign busy       = (r_state == S_COUNT);

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: stimulus queues expected pulse events, a monitor checks them.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic reset;
  logic din;
  logic dout, rise_pulse, busy;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic fall_pulse;
`endif

  always #5 clk = ~clk;

  debounce_sync #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dout       (dout),
    .rise_pulse (rise_pulse),
    .busy       (busy)
`ifdef DEBOUNCE_FALL_PULSE_EN
    ,
    .fall_pulse (fall_pulse)
`endif
  );

  typedef struct {
    bit is_fall;
    int edge_n;
    bit dout_exp;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  nvec = 0;
  int  nbad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic push(input bit f, input int e, input bit d);
    ev_t ev;
    ev.is_fall  = f;
    ev.edge_n   = e;
    ev.dout_exp = d;
    sb.push_back(ev);
  endtask

  // Monitor: any pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    bit r, f;
    ev_t ev;
    r = rise_pulse;
`ifdef DEBOUNCE_FALL_PULSE_EN
    f = fall_pulse;
`else
    f = 1'b0;
`endif
    if (r || f) begin
      if (sb.size() == 0) begin
        nvec++;
        nbad++;
        $display("FAIL unexpected_pulse: rise=%0b fall=%0b at edge %0d, none expected", r, f, cyc);
      end else begin
        ev = sb.pop_front();
        chk("pulse_rise", int'(r), int'(!ev.is_fall));
        chk("pulse_fall", int'(f), int'(ev.is_fall));
        chk("pulse_edge", cyc, ev.edge_n);
        chk("pulse_dout", int'(dout), int'(ev.dout_exp));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time bound, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k, r;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset = 1'b0;
    din   = 1'b0;

    // Reset held with toggling input
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din = ~din;
      chk("rst_dout", int'(dout), 0);
      chk("rst_rise", int'(rise_pulse), 0);
      chk("rst_busy", int'(busy), 0);
`ifdef DEBOUNCE_FALL_PULSE_EN
      chk("rst_fall", int'(fall_pulse), 0);
`endif
    end
    @(negedge clk);
    din   = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Clean press
    din = 1'b1;
    k = cyc + 1;
    push(1'b0, k + 5, 1'b1);
    wait_edge(k + 1); chk("press_busy_k1", int'(busy), 0);
    wait_edge(k + 2); chk("press_busy_k2", int'(busy), 1);
    wait_edge(k + 4); chk("press_busy_k4", int'(busy), 1);
                      chk("press_dout_k4", int'(dout), 0);
    wait_edge(k + 5); chk("press_busy_k5", int'(busy), 0);
                      chk("press_dout_k5", int'(dout), 1);
    wait_edge(k + 8);

    // Release
    din = 1'b0;
    k = cyc + 1;
`ifdef DEBOUNCE_FALL_PULSE_EN
    push(1'b1, k + 5, 1'b0);
`endif
    wait_edge(k + 4); chk("rel_dout_k4", int'(dout), 1);
    wait_edge(k + 5); chk("rel_dout_k5", int'(dout), 0);
                      chk("rel_busy_k5", int'(busy), 0);
    wait_edge(k + 8);

    // Glitch: three samples high, never committed
    din = 1'b1;
    k = cyc + 1;
    wait_edge(k + 2);
    din = 1'b0;
    wait_edge(k + 4);  chk("glitch_busy_k4", int'(busy), 1);
    wait_edge(k + 12); chk("glitch_dout", int'(dout), 0);
                       chk("glitch_busy", int'(busy), 0);

    // Bounce 1,0,1,1,0,1 then steady 1: commit 5 edges after the last rise
    din = pat[0];
    k = cyc + 1;
    push(1'b0, k + 10, 1'b1);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      din = pat[i];
    end
    wait_edge(k + 9);  chk("bounce_dout_k9", int'(dout), 0);
    wait_edge(k + 10); chk("bounce_dout_k10", int'(dout), 1);
    wait_edge(k + 14);

    din = 1'b0;
    k = cyc + 1;
`ifdef DEBOUNCE_FALL_PULSE_EN
    push(1'b1, k + 5, 1'b0);
`endif
    wait_edge(k + 5); chk("down_dout", int'(dout), 0);
    wait_edge(k + 8);

    // Reset mid-count (cnt=2), release with din held high
    din = 1'b1;
    k = cyc + 1;
    wait_edge(k + 3); chk("midrst_busy_pre", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_rise", int'(rise_pulse), 0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy_hold", int'(busy), 0);
    reset = 1'b1;
    r = cyc + 1;
    push(1'b0, r + 5, 1'b1);
    wait_edge(r + 1); chk("rel_rst_busy_r1", int'(busy), 0);
    wait_edge(r + 4); chk("rel_rst_dout_r4", int'(dout), 0);
                      chk("rel_rst_busy_r4", int'(busy), 1);
    wait_edge(r + 5); chk("rel_rst_dout_r5", int'(dout), 1);
    wait_edge(r + 10);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
